slow_clock_monitor: RTL

Consumes a slow toggling clock (such as the 100/200/400 Hz divider output) in the fast `clock` domain. It synchronizes the input and emits a one-cycle `tick` per rising edge. It also measures the half-period between consecutive edges and tracks lock/loss of the slow clock. Motor-step and sequencing logic use `tick` as a clock enable, and use `locked`/`lost` to gate or abort motion.

---
 rtl/slow_clock_monitor_pkg.sv | 21 ++
 rtl/slow_clock_monitor_if.sv | 23 ++
 rtl/sync_edge_detect.sv | 35 +++
 rtl/slow_clock_monitor.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/slow_clock_monitor_pkg.sv
// Shared types and constants for the slow clock monitor.
// Half-period defaults are in 25 MHz cycles.
package slow_clock_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_LOCKED,
        ST_LOST
    } mon_state_e;

    localparam int HALF_100HZ = 125000;
    localparam int HALF_200HZ = 62500;
    localparam int HALF_400HZ = 31250;

    // True when the interval lies within +/- tol of nominal.
    function automatic logic interval_ok(input int interval, input int nominal, input int tol);
        return (interval >= nominal - tol) && (interval <= nominal + tol);
    endfunction

endpackage

// File: rtl/slow_clock_monitor_if.sv
// Signal bundle between the slow clock source/consumer side and the monitor.
// The monitor uses the slave modport.
interface slow_clock_monitor_if #(
    parameter int CNT_W = 18
);
    logic             slow_clock_in;
    logic             tick;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             locked;
    logic             lost;
    logic [7:0]       err_count;

    modport master (
        output slow_clock_in,
        input  tick, half_period, period_valid, locked, lost, err_count
    );

    modport slave (
        input  slow_clock_in,
        output tick, half_period, period_valid, locked, lost, err_count
    );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-stage synchronizer for an asynchronous level, with registered
// one-cycle rise/fall/any strobes.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o,
    output logic any_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign any_o  = rise_q | fall_q;
endmodule

// File: rtl/slow_clock_monitor.sv
// Slow clock monitor: rising-edge tick, edge-to-edge interval measurement,
// and lock/loss tracking of an asynchronous slow clock.
module slow_clock_monitor
    import slow_clock_monitor_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int NOMINAL_HALF = HALF_400HZ,
    parameter int TOLERANCE    = 64,
    parameter int LOCK_COUNT   = 4,
    parameter int CNT_W        = 18
) (
    input logic                 clock,
    input logic                 reset,
    slow_clock_monitor_if.slave mon
);
    // state      | meaning
    // ST_IDLE    | out of reset; first edge only starts timing
    // ST_MEASURE | evaluating intervals, counting consecutive good ones
    // ST_LOCKED  | LOCK_COUNT consecutive good intervals seen
    // ST_LOST    | no edge for 2*NOMINAL_HALF; next edge restarts timing

    localparam int TIMEOUT = 2 * NOMINAL_HALF;
    localparam int GOOD_W  = $clog2(LOCK_COUNT + 1);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [7:0]       err_q, err_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic             pv_q, pv_d;
    logic             tick_q, locked_q, lost_q;

    logic             rise, edge_any, unused_fall;
    logic [CNT_W-1:0] interval;
    logic             interval_good;
    logic             timeout_hit;
    logic             eval_edge;
    logic             err_inc;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock  (clock),
        .reset  (reset),
        .async_i(mon.slow_clock_in),
        .rise_o (rise),
        .fall_o (unused_fall),
        .any_o  (edge_any)
    );

    assign interval      = cnt_q + 1'b1;
    assign interval_good = interval_ok(32'(interval), NOMINAL_HALF, TOLERANCE);
    // An edge arriving on the timeout cycle takes priority over the timeout.
    assign timeout_hit   = !edge_any && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        err_d     = err_q;
        hp_d      = hp_q;
        pv_d      = pv_q;
        eval_edge = 1'b0;
        err_inc   = 1'b0;
        cnt_d     = edge_any ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + 1'b1);

        case (state_q)
            ST_IDLE: begin
                if (edge_any) begin
                    state_d = ST_MEASURE;
                    good_d  = '0;
                end else if (timeout_hit) begin
                    state_d = ST_LOST;
                end
            end
            ST_MEASURE: begin
                if (edge_any) begin
                    eval_edge = 1'b1;
                    if (interval_good) begin
                        if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        good_d  = '0;
                        err_inc = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_LOST;
                end
            end
            ST_LOCKED: begin
                if (edge_any) begin
                    eval_edge = 1'b1;
                    if (!interval_good) begin
                        state_d = ST_MEASURE;
                        good_d  = '0;
                        err_inc = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_LOST;
                end
            end
            ST_LOST: begin
                if (edge_any) begin
                    state_d = ST_MEASURE;
                    good_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (eval_edge) begin
            hp_d = interval;
            pv_d = 1'b1;
        end
        if (state_d == ST_LOST && state_q != ST_LOST) begin
            pv_d = 1'b0;
        end
        if (err_inc && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            good_q   <= '0;
            err_q    <= '0;
            hp_q     <= '0;
            pv_q     <= 1'b0;
            tick_q   <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            err_q    <= err_d;
            hp_q     <= hp_d;
            pv_q     <= pv_d;
            tick_q   <= rise;
            locked_q <= (state_d == ST_LOCKED);
            lost_q   <= (state_d == ST_LOST);
        end
    end

    assign mon.tick         = tick_q;
    assign mon.half_period  = hp_q;
    assign mon.period_valid = pv_q;
    assign mon.locked       = locked_q;
    assign mon.lost         = lost_q;
    assign mon.err_count    = err_q;
endmodule
